// File: rtl/victim_cache_ctrl_if.sv
// Victim cache controller bus: lookup/insert
// requests, datapath command and response.
interface victim_cache_ctrl_if #(
  parameter int ENTRIES = 8,
  parameter int TAG_W   = 44,
  parameter int IDX_W   = 6
);
  localparam int WAY_W = $clog2(ENTRIES);

  logic             flush;
  logic             lk_valid;
  logic             lk_ready;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] lk_idx;
  logic             ins_valid;
  logic             ins_ready;
  logic [TAG_W-1:0] ins_tag;
  logic [IDX_W-1:0] ins_idx;
  logic             vc_op_valid;
  logic             vc_op_write;
  logic [WAY_W-1:0] vc_op_way;
  logic             resp_valid;
  logic             resp_hit;
  logic [WAY_W-1:0] resp_way;
  logic             busy;

  modport master (
    output flush,
    output lk_valid, lk_tag, lk_idx,
    output ins_valid, ins_tag, ins_idx,
    input  lk_ready, ins_ready,
    input  vc_op_valid, vc_op_write,
    input  vc_op_way,
    input  resp_valid, resp_hit, resp_way,
    input  busy
  );

  modport slave (
    input  flush,
    input  lk_valid, lk_tag, lk_idx,
    input  ins_valid, ins_tag, ins_idx,
    output lk_ready, ins_ready,
    output vc_op_valid, vc_op_write,
    output vc_op_way,
    output resp_valid, resp_hit, resp_way,
    output busy
  );
endinterface

// File: rtl/victim_cache_ctrl.sv
// Victim cache controller: arbitration, tag/LRU
// state and a 3-stage TL/TV/DM command pipeline.
module victim_cache_ctrl #(
  parameter int ENTRIES      = 8,
  parameter int TAG_W        = 44,
  parameter int IDX_W        = 6,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               reset,
  victim_cache_ctrl_if.slave bus
);
  localparam int WAY_W = $clog2(ENTRIES);
  localparam int DEF_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic             v;
    logic             lk;
    logic             hit;
    logic             write;
    logic [WAY_W-1:0] way;
  } stage_t;

  logic [ENTRIES-1:0] vld_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [IDX_W-1:0]   idx_q [ENTRIES];
  logic [WAY_W-1:0]   age_q [ENTRIES];
  logic [DEF_W-1:0]   defer_q;
  stage_t             s1_q, s2_q, s3_q;
  stage_t             s1_d;

  logic               starved;
  logic               lk_go, ins_go;
  logic [ENTRIES-1:0] lk_vec, ins_vec;
  logic               lk_hit, ins_hit;
  logic [WAY_W-1:0]   lk_way, ins_hit_way;
  logic               inv_found;
  logic [WAY_W-1:0]   inv_way, lru_way;
  logic [WAY_W-1:0]   ins_way, old_age;

  assign starved = bus.ins_valid &&
    (defer_q == DEF_W'(STARVE_LIMIT));

  // Arbitration: flush blocks all, starved insert wins
  always_comb begin
    bus.lk_ready  = 1'b0;
    bus.ins_ready = 1'b0;
    if (!bus.flush) begin
      if (starved) begin
        bus.ins_ready = 1'b1;
      end else begin
        bus.lk_ready  = 1'b1;
        bus.ins_ready = !bus.lk_valid;
      end
    end
  end

  assign lk_go  = bus.lk_valid && bus.lk_ready;
  assign ins_go = bus.ins_valid && bus.ins_ready;

  // Tag match and way encode for both requesters
  always_comb begin
    lk_way      = '0;
    ins_hit_way = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      lk_vec[i] = vld_q[i] &&
        tag_q[i] == bus.lk_tag &&
        idx_q[i] == bus.lk_idx;
      ins_vec[i] = vld_q[i] &&
        tag_q[i] == bus.ins_tag &&
        idx_q[i] == bus.ins_idx;
      if (lk_vec[i])  lk_way      = WAY_W'(i);
      if (ins_vec[i]) ins_hit_way = WAY_W'(i);
    end
    lk_hit  = |lk_vec;
    ins_hit = |ins_vec;
  end

  // Insert victim way: refresh, else free, else LRU
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!vld_q[i] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(i);
      end
      if (age_q[i] == WAY_W'(ENTRIES - 1))
        lru_way = WAY_W'(i);
    end
    priority case (1'b1)
      ins_hit:   ins_way = ins_hit_way;
      inv_found: ins_way = inv_way;
      default:   ins_way = lru_way;
    endcase
    old_age = age_q[ins_way];
  end

  // Per-way valid/tag/idx/age state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        idx_q[i] <= '0;
        age_q[i] <= WAY_W'(i);
      end
    end else if (bus.flush) begin
      vld_q <= '0;
    end else if (lk_go) begin
      if (lk_hit) vld_q[lk_way] <= 1'b0;
    end else if (ins_go) begin
      vld_q[ins_way] <= 1'b1;
      tag_q[ins_way] <= bus.ins_tag;
      idx_q[ins_way] <= bus.ins_idx;
      for (int i = 0; i < ENTRIES; i++) begin
        if (WAY_W'(i) == ins_way)
          age_q[i] <= '0;
        else if (age_q[i] < old_age)
          age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end

  // Count cycles a pending insert has lost
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      defer_q <= '0;
    else if (!bus.ins_valid || ins_go)
      defer_q <= '0;
    else if (defer_q != DEF_W'(STARVE_LIMIT))
      defer_q <= defer_q + 1'b1;
  end

  always_comb begin
    s1_d       = '0;
    s1_d.v     = lk_go || ins_go;
    s1_d.lk    = lk_go;
    s1_d.hit   = lk_go && lk_hit;
    s1_d.write = ins_go;
    if (ins_go)
      s1_d.way = ins_way;
    else if (lk_go && lk_hit)
      s1_d.way = lk_way;
  end

  // TL -> TV -> DM pipeline, immune to flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign bus.vc_op_valid = s1_q.v;
  assign bus.vc_op_write = s1_q.write;
  assign bus.vc_op_way   = s1_q.way;
  assign bus.resp_valid  = s3_q.v && s3_q.lk;
  assign bus.resp_hit    = s3_q.hit;
  assign bus.resp_way    =
    s3_q.lk ? s3_q.way : '0;
  assign bus.busy = s1_q.v | s2_q.v | s3_q.v;
endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Directed bench for victim_cache_ctrl: insert,
// lookup, LRU, starvation, flush and reset.
module tb_victim_cache_ctrl;
  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  victim_cache_ctrl_if #(
    .ENTRIES(8), .TAG_W(44), .IDX_W(6)
  ) bus ();

  victim_cache_ctrl #(
    .ENTRIES(8), .TAG_W(44), .IDX_W(6),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h",
                tag, obs, exp);
  endtask

  task automatic do_insert(
    input logic [43:0] tag,
    input logic [5:0]  idx,
    input int          way,
    input string       name
  );
    bus.ins_valid = 1'b1;
    bus.ins_tag   = tag;
    bus.ins_idx   = idx;
    #1;
    check({name, " ins_ready"}, bus.ins_ready, 1);
    @(negedge clk);
    bus.ins_valid = 1'b0;
    check({name, " op_valid"}, bus.vc_op_valid, 1);
    check({name, " op_write"}, bus.vc_op_write, 1);
    check({name, " op_way"}, bus.vc_op_way, way);
  endtask

  task automatic do_lookup(
    input logic [43:0] tag,
    input logic [5:0]  idx,
    input logic        hit,
    input int          way,
    input string       name
  );
    bus.lk_valid = 1'b1;
    bus.lk_tag   = tag;
    bus.lk_idx   = idx;
    #1;
    check({name, " lk_ready"}, bus.lk_ready, 1);
    @(negedge clk);
    bus.lk_valid = 1'b0;
    check({name, " op_valid"}, bus.vc_op_valid, 1);
    check({name, " op_write"}, bus.vc_op_write, 0);
    check({name, " op_way"}, bus.vc_op_way, way);
    check({name, " early_resp"}, bus.resp_valid, 0);
    @(negedge clk);
    @(negedge clk);
    check({name, " resp_valid"}, bus.resp_valid, 1);
    check({name, " resp_hit"}, bus.resp_hit, hit);
    check({name, " resp_way"}, bus.resp_way, way);
    @(negedge clk);
    check({name, " resp_once"}, bus.resp_valid, 0);
  endtask

  initial begin
    n_total       = 0;
    n_pass        = 0;
    reset         = 1'b0;
    bus.flush     = 1'b0;
    bus.lk_valid  = 1'b0;
    bus.lk_tag    = '0;
    bus.lk_idx    = '0;
    bus.ins_valid = 1'b0;
    bus.ins_tag   = '0;
    bus.ins_idx   = '0;

    repeat (2) @(negedge clk);
    check("rst op_valid", bus.vc_op_valid, 0);
    check("rst op_write", bus.vc_op_write, 0);
    check("rst op_way", bus.vc_op_way, 0);
    check("rst resp_valid", bus.resp_valid, 0);
    check("rst resp_hit", bus.resp_hit, 0);
    check("rst resp_way", bus.resp_way, 0);
    check("rst busy", bus.busy, 0);
    check("idle lk_ready", bus.lk_ready, 1);
    check("idle ins_ready", bus.ins_ready, 1);
    reset = 1'b1;
    @(negedge clk);

    // insert then consume by lookup
    do_insert(44'h123, 6'd5, 0, "ins0");
    check("ins0 busy", bus.busy, 1);
    do_lookup(44'h123, 6'd5, 1'b1, 0, "lk_hit");
    do_lookup(44'h123, 6'd5, 1'b0, 0, "lk_gone");

    // fill then LRU replacement
    for (int k = 0; k < 8; k++)
      do_insert(44'h200 + 44'(k), 6'd1, k, "fill");
    do_insert(44'h208, 6'd1, 0, "lru9");
    do_insert(44'h209, 6'd1, 1, "lru10");

    // refresh way 3 makes it MRU
    do_insert(44'h203, 6'd1, 3, "refresh");
    do_insert(44'h20A, 6'd1, 2, "after_ref1");
    do_insert(44'h20B, 6'd1, 4, "after_ref2");
    do_lookup(44'h203, 6'd1, 1'b1, 3, "lk_ref");

    // starvation: 4 lookups then 1 insert
    bus.lk_valid  = 1'b1;
    bus.lk_tag    = 44'hFFF;
    bus.lk_idx    = 6'd0;
    bus.ins_valid = 1'b1;
    bus.ins_tag   = 44'h300;
    bus.ins_idx   = 6'd2;
    for (int c = 0; c < 15; c++) begin
      #1;
      check("stv lk_ready", bus.lk_ready,
            (c % 5) != 4);
      check("stv ins_ready", bus.ins_ready,
            (c % 5) == 4);
      if (c > 0) begin
        check("stv op_valid", bus.vc_op_valid, 1);
        check("stv op_write", bus.vc_op_write,
              ((c - 1) % 5) == 4);
        check("stv op_way", bus.vc_op_way,
              (((c - 1) % 5) == 4) ? 3 : 0);
      end
      @(negedge clk);
    end
    bus.lk_valid  = 1'b0;
    bus.ins_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("drain busy", bus.busy, 0);

    // flush with three lookups in flight
    do_insert(44'h400, 6'd3, 5, "ins_x");
    bus.lk_valid = 1'b1;
    bus.lk_tag   = 44'h400;
    bus.lk_idx   = 6'd3;
    @(negedge clk);
    check("fl op1_way", bus.vc_op_way, 5);
    bus.lk_tag = 44'hAAA;
    bus.lk_idx = 6'd0;
    @(negedge clk);
    check("fl op2_way", bus.vc_op_way, 0);
    bus.lk_tag = 44'h300;
    bus.lk_idx = 6'd2;
    @(negedge clk);
    check("fl op3_way", bus.vc_op_way, 3);
    check("fl r1_valid", bus.resp_valid, 1);
    check("fl r1_hit", bus.resp_hit, 1);
    check("fl r1_way", bus.resp_way, 5);
    bus.flush     = 1'b1;
    bus.lk_tag    = 44'h400;
    bus.lk_idx    = 6'd3;
    bus.ins_valid = 1'b1;
    #1;
    check("fl lk_ready", bus.lk_ready, 0);
    check("fl ins_ready", bus.ins_ready, 0);
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.lk_valid  = 1'b0;
    bus.ins_valid = 1'b0;
    check("fl no_op", bus.vc_op_valid, 0);
    check("fl r2_valid", bus.resp_valid, 1);
    check("fl r2_hit", bus.resp_hit, 0);
    check("fl r2_way", bus.resp_way, 0);
    @(negedge clk);
    check("fl r3_valid", bus.resp_valid, 1);
    check("fl r3_hit", bus.resp_hit, 1);
    check("fl r3_way", bus.resp_way, 3);
    @(negedge clk);
    check("fl r_end", bus.resp_valid, 0);
    do_lookup(44'h400, 6'd3, 1'b0, 0, "post_fl1");
    do_lookup(44'h300, 6'd2, 1'b0, 0, "post_fl2");

    // reset mid-pipeline
    bus.ins_valid = 1'b1;
    bus.ins_tag   = 44'h500;
    bus.ins_idx   = 6'd4;
    @(negedge clk);
    bus.ins_valid = 1'b0;
    bus.lk_valid  = 1'b1;
    bus.lk_tag    = 44'h500;
    bus.lk_idx    = 6'd4;
    @(negedge clk);
    bus.lk_valid = 1'b0;
    check("mid busy", bus.busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mr op_valid", bus.vc_op_valid, 0);
    check("mr op_write", bus.vc_op_write, 0);
    check("mr op_way", bus.vc_op_way, 0);
    check("mr resp_valid", bus.resp_valid, 0);
    check("mr resp_hit", bus.resp_hit, 0);
    check("mr resp_way", bus.resp_way, 0);
    check("mr busy", bus.busy, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check("mr stale_resp", bus.resp_valid, 0);
      check("mr stale_busy", bus.busy, 0);
      @(negedge clk);
    end
    do_lookup(44'h500, 6'd4, 1'b0, 0, "mr_lk");
    do_insert(44'h600, 6'd7, 0, "mr_ins");

    $display("%0d/%0d checks passed",
             n_pass, n_total);
    $finish;
  end
endmodule
